pio_mailbox_arbiter: RTL and testbench



---
 rtl/pio_mailbox_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_pio_mailbox_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_mailbox_arbiter.sv
// -----------------------------------------------------------------------------
// pio_mailbox_arbiter
//
// Shares one HPS-readable 32-bit mailbox among NUM_REQ fabric producers.
// While the mailbox is empty, a round-robin arbiter grants one valid, unmasked
// producer. The granted word is captured, and the mailbox is then held until the
// HPS pops it over the Avalon-MM slave. After the pop, arbitration restarts.
//
// Ports
//   clk        system clock
//   reset_n    synchronous active-low reset, sampled on rising clk
//   req_valid  per-producer valid; data held stable until accepted
//   req_data   producer i word at bits [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant (combinational); transfer on valid & ready
//   address    Avalon word address: 0 DATA, 1 STATUS, 2 ACK, 3 CTRL
//   write      Avalon write strobe
//   writedata  Avalon write data
//   readdata   Avalon read data, registered mux of address every cycle
// -----------------------------------------------------------------------------
module pio_mailbox_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [1:0]                  address,
    input  logic                        write,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_W-1:0]     r_mbox_data;
    logic [ID_W-1:0]       r_mbox_id;
    logic [15:0]           r_cap_count;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [NUM_REQ-1:0]    r_mask;
    logic [31:0]           r_readdata;

    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_found;
    logic [ID_W-1:0]       w_gidx;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_hs;
    logic                  w_ack_wr;
    logic                  w_ctrl_wr;
    logic                  w_flush;
    logic [DATA_W-1:0]     w_sel_data;
    logic [ID_W-1:0]       w_rr_nxt;
    logic [31:0]           w_rdata;
    logic                  w_unused_ok;

    assign w_eligible = req_valid & r_mask;
    assign w_ack_wr   = write && (address == 2'd2) && writedata[0];
    assign w_ctrl_wr  = write && (address == 2'd3);
    assign w_flush    = w_ctrl_wr && writedata[31];
    assign w_sel_data = req_data[w_gidx*DATA_W +: DATA_W];
    assign w_rr_nxt   = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : (w_gidx + 1'b1);
    assign req_ready  = w_grant;
    assign readdata   = r_readdata;

    // Only bit 0 (ack), the mask field and bit 31 (flush) of writedata matter.
    assign w_unused_ok = ^writedata[30:NUM_REQ];

    // Round-robin scan: first eligible index starting at rr_ptr, wrapping.
    always_comb begin : arb_scan
        int idx;
        w_found = 1'b0;
        w_gidx  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_gidx  = ID_W'(idx);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and grant decode; grants are only offered while empty.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = '0;
        w_hs        = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_found) begin
                    w_grant = NUM_REQ'(1) << w_gidx;
                    w_hs    = 1'b1;
                    // A flush in the handshake cycle throws the capture away.
                    if (w_flush) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_ack_wr || w_flush) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Register-map read mux; registered below for one-cycle read latency.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (address)
            2'd0: begin
                w_rdata = 32'(r_mbox_data);
            end
            2'd1: begin
                w_rdata[0]         = (r_state == ST_FULL);
                w_rdata[8 +: ID_W] = r_mbox_id;
                w_rdata[31:16]     = r_cap_count;
            end
            2'd2: begin
                w_rdata = 32'h0000_0000;
            end
            2'd3: begin
                w_rdata = 32'(r_mask);
            end
            default: begin
                w_rdata = 32'h0000_0000;
            end
        endcase
    end

    // Mailbox state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mailbox contents, capture counter, round-robin pointer, mask, readback.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mbox_data <= '0;
            r_mbox_id   <= '0;
            r_cap_count <= 16'h0000;
            r_rr_ptr    <= '0;
            r_mask      <= '1;
            r_readdata  <= 32'h0000_0000;
        end else begin
            if (w_hs) begin
                // Counter and pointer advance even if a flush drops the word.
                r_cap_count <= r_cap_count + 16'h0001;
                r_rr_ptr    <= w_rr_nxt;
                if (!w_flush) begin
                    r_mbox_data <= w_sel_data;
                    r_mbox_id   <= w_gidx;
                end else begin
                    r_mbox_data <= r_mbox_data;
                end
            end else if ((r_state == ST_FULL) && (w_ack_wr || w_flush)) begin
                r_mbox_data <= '0;
            end else begin
                r_mbox_data <= r_mbox_data;
            end
            if (w_ctrl_wr) begin
                r_mask <= writedata[NUM_REQ-1:0];
            end else begin
                r_mask <= r_mask;
            end
            r_readdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_pio_mailbox_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pio_mailbox_arbiter
//
// Directed bench for pio_mailbox_arbiter (NUM_REQ=4, DATA_W=32). Inputs are
// driven 1 time unit after the rising edge. Combinational grants are checked
// before the next edge, and registered readback is checked after it.
// -----------------------------------------------------------------------------
module tb_pio_mailbox_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                       clk;
    logic                       reset_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic [1:0]                 address;
    logic                       write;
    logic [31:0]                writedata;
    logic [31:0]                readdata;

    int n_checks;
    int n_fail;
    logic [31:0] rd_val;

    pio_mailbox_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        write   = 1'b0;
        tick();
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = 32'h0000_0000;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_data  = '0;
        address   = 2'd0;
        write     = 1'b0;
        writedata = 32'h0000_0000;

        // Reset then idle.
        tick();
        tick();
        chk_eq("rst_readdata", readdata, 32'h0000_0000);
        chk_eq("rst_ready", 32'(req_ready), 32'h0);
        reset_n = 1'b1;
        rd(2'd3, rd_val);
        chk_eq("rst_ctrl", rd_val, 32'h0000_000F);
        rd(2'd1, rd_val);
        chk_eq("rst_status", rd_val, 32'h0000_0000);

        // Single producer on index 2.
        req_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        req_valid = 4'b0100;
        #1;
        chk_eq("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        chk_eq("single_ready_full", 32'(req_ready), 32'h0);
        rd(2'd0, rd_val);
        chk_eq("single_data", rd_val, 32'hDEAD_BEEF);
        rd(2'd1, rd_val);
        chk_eq("single_status", rd_val, 32'h0001_0201);
        wr(2'd2, 32'h0000_0001);
        rd(2'd1, rd_val);
        chk_eq("single_pop_status", rd_val, 32'h0001_0200);
        rd(2'd0, rd_val);
        chk_eq("single_pop_data", rd_val, 32'h0000_0000);

        // Round-robin fairness from a fresh reset.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = 32'h10 + 32'(i);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_eq($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(1) << (i % 4));
            tick();
            rd(2'd0, rd_val);
            chk_eq($sformatf("rr_data_%0d", i), rd_val, 32'h10 + 32'(i % 4));
            wr(2'd2, 32'h0000_0001);
        end
        req_valid = 4'b0000;
        rd(2'd1, rd_val);
        chk_eq("rr_count", rd_val, 32'h0005_0000);

        // Backpressure: producer 1 waits while the mailbox is full.
        req_valid = 4'b0001;
        #1;
        chk_eq("bp_first_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010;
        chk_eq("bp_full_ready0", 32'(req_ready), 32'h0);
        tick();
        chk_eq("bp_full_ready1", 32'(req_ready), 32'h0);
        address   = 2'd2;
        writedata = 32'h0000_0001;
        write     = 1'b1;
        #1;
        chk_eq("bp_ack_cycle_ready", 32'(req_ready), 32'h0);
        tick();
        write = 1'b0;
        chk_eq("bp_after_ack_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        rd(2'd0, rd_val);
        chk_eq("bp_data", rd_val, 32'h0000_0011);
        rd(2'd1, rd_val);
        chk_eq("bp_status", rd_val, 32'h0007_0101);
        wr(2'd2, 32'h0000_0001);

        // Mask and flush.
        wr(2'd3, 32'h0000_0005);
        req_valid = 4'b1111;
        #1;
        chk_eq("mask_ready_a", 32'(req_ready), 32'h4);
        tick();
        wr(2'd2, 32'h0000_0001);
        chk_eq("mask_ready_b", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        wr(2'd3, 32'h8000_0005);
        rd(2'd1, rd_val);
        chk_eq("flush_status", rd_val, 32'h0009_0000);
        rd(2'd3, rd_val);
        chk_eq("flush_mask", rd_val, 32'h0000_0005);
        wr(2'd3, 32'h0000_0000);
        req_valid = 4'b1111;
        #1;
        chk_eq("mask0_ready", 32'(req_ready), 32'h0);
        rd(2'd1, rd_val);
        chk_eq("mask0_status", rd_val, 32'h0009_0000);
        req_valid = 4'b0000;
        wr(2'd3, 32'h0000_000F);

        // Counter wrap via flush-in-handshake-cycle, one capture per cycle.
        req_valid = 4'b0001;
        address   = 2'd3;
        writedata = 32'h8000_000F;
        write     = 1'b1;
        repeat (65535 - 9) @(posedge clk);
        #1;
        write     = 1'b0;
        writedata = 32'h0000_0000;
        req_valid = 4'b0000;
        rd(2'd1, rd_val);
        chk_eq("wrap_pre_status", rd_val & 32'hFFFF_00FF, 32'hFFFF_0000);
        req_valid = 4'b0001;
        #1;
        chk_eq("wrap_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        rd(2'd1, rd_val);
        chk_eq("wrap_status", rd_val, 32'h0000_0001);

        // Reset asserted on a handshake cycle.
        wr(2'd2, 32'h0000_0001);
        req_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        req_valid = 4'b0100;
        #1;
        chk_eq("rstmid_ready", 32'(req_ready), 32'h4);
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        req_valid = 4'b0000;
        chk_eq("rstmid_readdata", readdata, 32'h0000_0000);
        rd(2'd1, rd_val);
        chk_eq("rstmid_status", rd_val, 32'h0000_0000);
        rd(2'd0, rd_val);
        chk_eq("rstmid_data", rd_val, 32'h0000_0000);
        rd(2'd3, rd_val);
        chk_eq("rstmid_mask", rd_val, 32'h0000_000F);
        req_valid = 4'b1111;
        #1;
        chk_eq("rstmid_rrptr", 32'(req_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
